// File: rtl/mem_ctrl_arb_if.sv
// Bus bundle between the RAM arbiter, its two clients (fetcher, load/store buffer) and the RAM/UART.
// master is the arbiter's view; slave is the clients-plus-memory side.
interface mem_ctrl_arb_if #(
   parameter int ADDR_LEN = 32
);
   logic                uart_full_from_ram;
   logic                wr_flag_to_ram;
   logic [ADDR_LEN-1:0] addr_to_ram;
   logic [7:0]          data_i_from_ram;
   logic [7:0]          data_o_to_ram;

   logic                ena_from_if;
   logic [ADDR_LEN-1:0] pc_from_if;
   logic                ok_flag_to_if;
   logic [31:0]         inst_to_if;

   logic                ena_from_lsb;
   logic                wr_flag_from_lsb;
   logic [ADDR_LEN-1:0] addr_from_lsb;
   logic [1:0]          size_from_lsb;
   logic [31:0]         data_from_lsb;
   logic                ok_flag_to_lsb;
   logic [31:0]         data_to_lsb;

   modport master (
      input  uart_full_from_ram, data_i_from_ram,
      input  ena_from_if, pc_from_if,
      input  ena_from_lsb, wr_flag_from_lsb, addr_from_lsb, size_from_lsb, data_from_lsb,
      output wr_flag_to_ram, addr_to_ram, data_o_to_ram,
      output ok_flag_to_if, inst_to_if,
      output ok_flag_to_lsb, data_to_lsb
   );

   modport slave (
      output uart_full_from_ram, data_i_from_ram,
      output ena_from_if, pc_from_if,
      output ena_from_lsb, wr_flag_from_lsb, addr_from_lsb, size_from_lsb, data_from_lsb,
      input  wr_flag_to_ram, addr_to_ram, data_o_to_ram,
      input  ok_flag_to_if, inst_to_if,
      input  ok_flag_to_lsb, data_to_lsb
   );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Byte-serial RAM controller: round-robin between instruction fetch and load/store buffer,
// 1/2/4-byte accesses, UART back-pressure on I/O stores, and pipeline-clear abort of reads.
module mem_ctrl_arb #(
   parameter int          ADDR_LEN = 32,
   parameter int unsigned IO_BASE  = 32'h30000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   input  logic           clr_from_rob,
   mem_ctrl_arb_if.master bus
);
   typedef enum logic [1:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE} state_t;

   localparam logic [ADDR_LEN-1:0] IO_ADDR = ADDR_LEN'(IO_BASE);

   state_t              state;
   logic                last_lsb;
   logic [ADDR_LEN-1:0] base;
   logic [2:0]          cnt;
   logic [2:0]          n;
   logic [31:0]         wdata;

   logic                req_if;
   logic                req_lsb;
   logic                grant_lsb;
   logic [ADDR_LEN-1:0] next_addr;
   logic [1:0]          cap_idx;
   logic                stall;

   function automatic logic [2:0] size_to_n(input logic [1:0] s);
      case (s)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction

   function automatic logic is_io(input logic [ADDR_LEN-1:0] a);
      return a >= IO_ADDR;
   endfunction

   // A client still showing its ok pulse is not eligible, so a held request is not re-accepted.
   always_comb begin
      req_if    = bus.ena_from_if  && !bus.ok_flag_to_if;
      req_lsb   = bus.ena_from_lsb && !bus.ok_flag_to_lsb;
      grant_lsb = req_lsb && (!req_if || !last_lsb);
      next_addr = base + ADDR_LEN'(cnt) + ADDR_LEN'(1);
      cap_idx   = cnt[1:0] - 2'd1;
      stall     = is_io(bus.addr_to_ram) && bus.uart_full_from_ram;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         last_lsb           <= 1'b1;
         cnt                <= '0;
         bus.wr_flag_to_ram <= 1'b0;
         bus.addr_to_ram    <= '0;
         bus.data_o_to_ram  <= '0;
         bus.ok_flag_to_if  <= 1'b0;
         bus.inst_to_if     <= '0;
         bus.ok_flag_to_lsb <= 1'b0;
         bus.data_to_lsb    <= '0;
      end else if (rdy) begin
         bus.ok_flag_to_if  <= 1'b0;
         bus.ok_flag_to_lsb <= 1'b0;
         case (state)
            IDLE: begin
               if (!clr_from_rob && (req_if || req_lsb)) begin
                  cnt <= '0;
                  if (grant_lsb) begin
                     last_lsb        <= 1'b1;
                     base            <= bus.addr_from_lsb;
                     n               <= size_to_n(bus.size_from_lsb);
                     wdata           <= bus.data_from_lsb;
                     bus.addr_to_ram <= bus.addr_from_lsb;
                     if (bus.wr_flag_from_lsb) begin
                        state              <= LSB_WRITE;
                        bus.data_o_to_ram  <= bus.data_from_lsb[7:0];
                        bus.wr_flag_to_ram <= !(is_io(bus.addr_from_lsb) && bus.uart_full_from_ram);
                     end else begin
                        state              <= LSB_READ;
                        bus.wr_flag_to_ram <= 1'b0;
                        bus.data_to_lsb    <= '0;
                     end
                  end else begin
                     last_lsb           <= 1'b0;
                     base               <= bus.pc_from_if;
                     n                  <= 3'd4;
                     bus.addr_to_ram    <= bus.pc_from_if;
                     bus.wr_flag_to_ram <= 1'b0;
                     bus.inst_to_if     <= '0;
                     state              <= IF_READ;
                  end
               end
            end
            IF_READ, LSB_READ: begin
               if (clr_from_rob) begin
                  state              <= IDLE;
                  bus.wr_flag_to_ram <= 1'b0;
                  bus.addr_to_ram    <= '0;
               end else begin
                  // Read data trails its address by one edge, so byte cnt-1 arrives now.
                  if (cnt != 3'd0) begin
                     if (state == IF_READ) bus.inst_to_if[{cap_idx, 3'b000} +: 8]  <= bus.data_i_from_ram;
                     else                  bus.data_to_lsb[{cap_idx, 3'b000} +: 8] <= bus.data_i_from_ram;
                  end
                  if (cnt == n) begin
                     state           <= IDLE;
                     bus.addr_to_ram <= '0;
                     if (state == IF_READ) bus.ok_flag_to_if  <= 1'b1;
                     else                  bus.ok_flag_to_lsb <= 1'b1;
                  end else begin
                     bus.addr_to_ram <= (cnt >= n - 3'd1) ? '0 : next_addr;
                     cnt             <= cnt + 3'd1;
                  end
               end
            end
            LSB_WRITE: begin
               // wr low means the current byte is parked behind a full UART; re-present it once drained.
               if (!bus.wr_flag_to_ram) begin
                  bus.wr_flag_to_ram <= !stall;
               end else if (cnt == n - 3'd1) begin
                  state              <= IDLE;
                  bus.wr_flag_to_ram <= 1'b0;
                  bus.addr_to_ram    <= '0;
                  bus.ok_flag_to_lsb <= 1'b1;
               end else begin
                  cnt                <= cnt + 3'd1;
                  bus.addr_to_ram    <= next_addr;
                  bus.data_o_to_ram  <= byte_sel(wdata, cnt[1:0] + 2'd1);
                  bus.wr_flag_to_ram <= !(is_io(next_addr) && bus.uart_full_from_ram);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
